axi4_lite_regfile: RTL and testbench
====================================

// Module: axi4_lite_regfile
// PURPOSE
//   Parametrised AXI4-Lite subordinate register file; successor to the fixed two-register axi4_lite_sub.
//   Adds NUM_REGS registers, WSTRB byte lanes, read-only status registers, SLVERR decode and
//   independent AW/W arrival. Sits behind the AXI4-Lite interconnect (or the AXI VIP master in sim).
//   Exposes register contents and write strobes to fabric logic.
// PARAMETERS
//   DATA_WIDTH  32   bus/register width; 32 or 64
//   ADDR_WIDTH  32   address width
//   NUM_REGS    8    number of registers, >=1
//   RO_MASK     '0   [NUM_REGS] bit i=1 -> register i is read-only, value taken from reg_in
//   RESET_VAL   '0   [NUM_REGS*DATA_WIDTH] per-register reset value (RW registers)
// PORTS
//   aclk       in   1                     clock
//   aresetn    in   1                     async active-low reset
//   s_axi      -    axi4_if.subordinate   AW/W/B/AR/R channels; wstrb is DATA_WIDTH/8 bits
//   reg_out    out  NUM_REGS*DATA_WIDTH   current register values (RO entries mirror reg_in)
//   reg_in     in   NUM_REGS*DATA_WIDTH   status values for RO registers; ignored for RW
//   wr_pulse   out  NUM_REGS              1-cycle pulse, cycle after a register is written
// BEHAVIOUR
//   Reset
//   - Asynchronous, active-low.
//   - While aresetn=0: all READY/VALID outputs=0, bresp/rresp=OKAY, rdata=0, wr_pulse=0,
//     RW registers=RESET_VAL.
//   - READY outputs rise on the first aclk edge after deassert.
//   Decode
//   - ADDR_LSB=$clog2(DATA_WIDTH/8). idx=addr[ADDR_WIDTH-1:ADDR_LSB]; addr[ADDR_LSB-1:0] ignored.
//   - idx>=NUM_REGS -> out of range. AxPROT ignored.
//   Write path
//   - AW and W accepted independently, in either order or the same cycle, into holding regs.
//   - awready=!aw_held && !bvalid; wready=!w_held && !bvalid. Registered flags.
//   - Once both are held, the register is updated on the next edge: per byte, if wstrb[b]=1,
//     take the wdata byte, else keep the old byte.
//   - Same edge: bvalid=1, wr_pulse[idx]=1 (RW and in range only).
//   - Latency: bvalid is asserted 1 cycle after the later of the AW/W handshakes.
//   - bvalid/bresp stay stable until bready. Holding flags clear on the B handshake.
//   - Next AW/W is accepted the cycle after the B handshake (no overlap; one outstanding write).
//   - Out of range, or RO register: no state change, no wr_pulse, bresp=SLVERR(2'b10).
//   - wstrb=0 to a RW register: no data change, wr_pulse still fires, OKAY.
//   Read path
//   - arready=!rvalid.
//   - AR handshake -> next edge: rvalid=1, rdata=reg value (RO: reg_in sampled at that edge),
//     rresp=OKAY.
//   - Out of range: rdata=0, rresp=SLVERR.
//   - rdata/rresp held stable until rready. arready returns 1 the cycle after the R handshake.
//   Simultaneous events
//   - Read and write to the same register resolving on one edge: the read returns the old value.
//   - The read and write channels never stall each other.
//   Mid-transaction reset
//   - Pending AW/W/AR are dropped. No B/R response is issued afterwards.
// STRUCTURE
//   - axi4_lite_pkg: typedef enum logic[1:0] axi_resp_t {RESP_OKAY=2'b00, RESP_SLVERR=2'b10};
//     function strb_merge(old,new,strb).
//   - Write collector (aw_held/w_held/bvalid) and read responder are separate always_ff blocks
//     in this module.
//   - One sub-module is natural: axi4_lite_wr_collect (AW/W capture + B response).
// TESTING (DATA_WIDTH=32, NUM_REGS=8, RO_MASK=8'h80, reg_in[7]=32'hC0DE_0007)
//   1. Reset 20us, read 0x00 -> 0x0/OKAY; write 0x00=DEAD_BEEF strb F -> OKAY; read -> DEAD_BEEF.
//   2. Write 0x04=ADAD_ABAB, then 0x04=1122_3344 strb 4'b0101 -> read 0x04 = AD22_AB44;
//      wr_pulse[1] pulses twice.
//   3. W (0x0000_00AA) 3 cycles before AW (0x08) -> wready low while held; one bvalid,
//      1 cycle after AW handshake; read 0x08 = 0xAA.
//   4. Write/read 0x20 and 0x1C -> SLVERR; 0x20 read rdata=0; 0x1C read = C0DE_0007;
//      no reg_out change, no wr_pulse.
//   5. bready low 5 cycles after write -> bvalid/bresp stable, awready=wready=0;
//      concurrent read 0x00 completes meanwhile.
//   6. Write 0x00=BEBE_BABA, assert reset mid-AR, deassert -> no stale rvalid; read 0x00 = RESET_VAL[0].

Source files
------------

// File: rtl/axi4_lite_regfile_pkg.sv
// Shared types and helpers for the AXI4-Lite register file: response codes and byte-lane merge.
package axi4_lite_regfile_pkg;

    localparam int MAX_DW = 64;
    localparam int MAX_SW = MAX_DW / 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_t;

    // Callers zero-extend narrower words to MAX_DW and truncate the result back.
    function automatic logic [MAX_DW-1:0] strb_merge(
        input logic [MAX_DW-1:0] old_word,
        input logic [MAX_DW-1:0] new_word,
        input logic [MAX_SW-1:0] strb
    );
        logic [MAX_DW-1:0] res;
        res = old_word;
        for (int b = 0; b < MAX_SW; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_lite_regfile_if.sv
// AXI4-Lite channel bundle between a manager and the register file subordinate.
interface axi4_lite_regfile_if
    import axi4_lite_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();

    localparam int STRB_W = DATA_WIDTH / 8;

    // Every channel: a transfer happens on an aclk edge where valid && ready are both 1.
    // Once raised, valid and its payload hold until that edge; ready may change freely.
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     wstrb;
    logic                  wvalid;
    logic                  wready;

    axi_resp_t             bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    axi_resp_t             rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport subordinate (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axi4_lite_regfile_wr_collect.sv
// Captures AW and W independently, fires a one-cycle commit once both are held, and owns the B channel.
module axi4_lite_regfile_wr_collect
    import axi4_lite_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    awvalid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awready,
    input  logic                    wvalid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wready,
    output logic                    bvalid,
    output axi_resp_t               bresp,
    input  logic                    bready,
    input  logic                    wr_err,
    output logic                    wr_commit,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_strb
);

    logic      run;
    logic      aw_held;
    logic      w_held;
    logic      bvalid_q;
    axi_resp_t bresp_q;

    // run keeps the ready outputs low until the first edge after reset release.
    assign awready   = run && !aw_held && !bvalid_q;
    assign wready    = run && !w_held && !bvalid_q;
    assign wr_commit = aw_held && w_held && !bvalid_q;
    assign bvalid    = bvalid_q;
    assign bresp     = bresp_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run      <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_strb  <= '0;
        end else begin
            run <= 1'b1;
            if (awvalid && awready) begin
                aw_held <= 1'b1;
                wr_addr <= awaddr;
            end
            if (wvalid && wready) begin
                w_held  <= 1'b1;
                wr_data <= wdata;
                wr_strb <= wstrb;
            end
            if (wr_commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && bready) begin
                bvalid_q <= 1'b0;
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi4_lite_regfile.sv
// Parametrised AXI4-Lite register file with byte strobes, read-only status entries and SLVERR decode.
module axi4_lite_regfile
    import axi4_lite_regfile_pkg::*;
#(
    parameter int                           DATA_WIDTH = 32,
    parameter int                           ADDR_WIDTH = 32,
    parameter int                           NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0]          RO_MASK    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    axi4_lite_regfile_if.subordinate       s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_WIDTH-1:0] regs    [NUM_REGS];
    logic [DATA_WIDTH-1:0] out_arr [NUM_REGS];

    logic                  wr_commit;
    logic                  wr_err;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [IDX_W-1:0]      wr_idx;
    logic [SEL_W-1:0]      wr_sel;
    logic                  wr_in_range;

    logic [IDX_W-1:0]      rd_idx;
    logic [SEL_W-1:0]      rd_sel;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  rd_run;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    axi_resp_t             rresp_q;

    logic                  unused_ok;
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.araddr[ADDR_LSB-1:0], wr_addr[ADDR_LSB-1:0]};

    axi4_lite_regfile_wr_collect #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_collect (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .awvalid   (s_axi.awvalid),
        .awaddr    (s_axi.awaddr),
        .awready   (s_axi.awready),
        .wvalid    (s_axi.wvalid),
        .wdata     (s_axi.wdata),
        .wstrb     (s_axi.wstrb),
        .wready    (s_axi.wready),
        .bvalid    (s_axi.bvalid),
        .bresp     (s_axi.bresp),
        .bready    (s_axi.bready),
        .wr_err    (wr_err),
        .wr_commit (wr_commit),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb)
    );

    // Write decode works on the held address, so it is stable for the whole commit cycle.
    assign wr_idx      = wr_addr[ADDR_WIDTH-1:ADDR_LSB];
    assign wr_sel      = wr_idx[SEL_W-1:0];
    assign wr_in_range = wr_idx < IDX_W'(NUM_REGS);
    assign wr_err      = wr_in_range ? RO_MASK[wr_sel] : 1'b1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
            end
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (wr_commit && !wr_err) begin
                regs[wr_sel]     <= DATA_WIDTH'(strb_merge(MAX_DW'(regs[wr_sel]),
                                                           MAX_DW'(wr_data),
                                                           MAX_SW'(wr_strb)));
                wr_pulse[wr_sel] <= 1'b1;
            end
        end
    end

    // Read-only entries present the live status input; their storage is never written.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign out_arr[i] = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = out_arr[i];
    end

    assign rd_idx      = s_axi.araddr[ADDR_WIDTH-1:ADDR_LSB];
    assign rd_sel      = rd_idx[SEL_W-1:0];
    assign rd_in_range = rd_idx < IDX_W'(NUM_REGS);

    always_comb begin
        rd_word = '0;
        if (rd_in_range) rd_word = out_arr[rd_sel];
    end

    assign s_axi.arready = rd_run && !rvalid_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    // Sampling regs before this edge's write lands gives old-value semantics on a same-edge collision.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_run   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_run <= 1'b1;
            if (s_axi.arvalid && s_axi.arready) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
                rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid_q && s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed bench for axi4_lite_regfile: 8 x 32-bit registers, register 7 read-only status.
module tb_axi4_lite_regfile;
    import axi4_lite_regfile_pkg::*;

    localparam logic [255:0] RST_VAL = {32'h0, 32'h0, 32'h0000_5555, 32'h0,
                                        32'h5A5A_0003, 32'h0, 32'h0, 32'h0};

    logic         aclk;
    logic         aresetn;
    logic [255:0] reg_out;
    logic [255:0] reg_in;
    logic [7:0]   wr_pulse;

    int total = 0;
    int bad   = 0;
    int pulse_cnt [8];

    axi4_lite_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    axi4_lite_regfile #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .NUM_REGS   (8),
        .RO_MASK    (8'h80),
        .RESET_VAL  (RST_VAL)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_axi    (bus),
        .reg_out  (reg_out),
        .reg_in   (reg_in),
        .wr_pulse (wr_pulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        for (int i = 0; i < 8; i++) pulse_cnt[i] = 0;
    end

    always @(negedge aclk) begin
        for (int i = 0; i < 8; i++) if (wr_pulse[i] === 1'b1) pulse_cnt[i]++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic aw_send(input logic [31:0] addr);
        int n = 0;
        @(negedge aclk);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        while (bus.awready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        if (bus.awready !== 1'b1) begin
            total++; bad++;
            $display("FAIL aw_timeout addr=%h got awready=%b want 1", addr, bus.awready);
        end
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        @(negedge aclk);
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        while (bus.wready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        if (bus.wready !== 1'b1) begin
            total++; bad++;
            $display("FAIL w_timeout data=%h got wready=%b want 1", data, bus.wready);
        end
        @(posedge aclk); #1;
        bus.wvalid = 1'b0;
    endtask

    task automatic b_wait(output axi_resp_t resp);
        int n = 0;
        @(negedge aclk);
        bus.bready = 1'b1;
        while (bus.bvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        if (bus.bvalid !== 1'b1) begin
            total++; bad++;
            $display("FAIL b_timeout got bvalid=%b want 1", bus.bvalid);
        end
        resp = bus.bresp;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic r_recv(output logic [31:0] data, output axi_resp_t resp);
        int n = 0;
        @(negedge aclk);
        bus.rready = 1'b1;
        while (bus.rvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        if (bus.rvalid !== 1'b1) begin
            total++; bad++;
            $display("FAIL r_timeout got rvalid=%b want 1", bus.rvalid);
        end
        data = bus.rdata;
        resp = bus.rresp;
        @(posedge aclk); #1;
        bus.rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output axi_resp_t resp);
        fork
            aw_send(addr);
            w_send(data, strb);
        join
        b_wait(resp);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output axi_resp_t resp);
        int n = 0;
        @(negedge aclk);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (bus.arready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        if (bus.arready !== 1'b1) begin
            total++; bad++;
            $display("FAIL ar_timeout addr=%h got arready=%b want 1", addr, bus.arready);
        end
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        r_recv(data, resp);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [31:0] d;
        axi_resp_t   r;
        aresetn = 1'b0;
        repeat (2000) @(negedge aclk);
        total++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_handshake got aw/w/ar/b/r=%b want 00000",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        end
        total++;
        if (bus.rdata !== 32'h0 || bus.bresp !== RESP_OKAY || bus.rresp !== RESP_OKAY || wr_pulse !== 8'h0) begin
            bad++;
            $display("FAIL reset_outputs got rdata=%h bresp=%b rresp=%b pulse=%h want 0/00/00/00",
                     bus.rdata, bus.bresp, bus.rresp, wr_pulse);
        end
        total++;
        if (reg_out[3*32 +: 32] !== 32'h5A5A_0003 || reg_out[5*32 +: 32] !== 32'h0000_5555) begin
            bad++;
            $display("FAIL reset_values got r3=%h r5=%h want 5a5a0003/00005555",
                     reg_out[3*32 +: 32], reg_out[5*32 +: 32]);
        end
        aresetn = 1'b1;
        #1;
        total++;
        if (bus.awready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge got awready=%b want 0", bus.awready);
        end
        @(posedge aclk); #1;
        total++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            bad++;
            $display("FAIL ready_after_edge got aw/w/ar=%b want 111",
                     {bus.awready, bus.wready, bus.arready});
        end
        do_read(32'h0, d, r);
        total++;
        if (d !== 32'h0 || r !== RESP_OKAY) begin
            bad++;
            $display("FAIL reset_read0 got %h/%b want 00000000/00", d, r);
        end
    endtask

    task automatic test_basic_write;
        logic [31:0] d;
        axi_resp_t   r;
        do_write(32'h0, 32'hDEAD_BEEF, 4'hF, r);
        total++;
        if (r !== RESP_OKAY) begin
            bad++;
            $display("FAIL basic_bresp got %b want 00", r);
        end
        do_read(32'h0, d, r);
        total++;
        if (d !== 32'hDEAD_BEEF || r !== RESP_OKAY || reg_out[31:0] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL basic_read got %h/%b reg_out=%h want deadbeef/00", d, r, reg_out[31:0]);
        end
    endtask

    task automatic test_strobes;
        logic [31:0] d;
        axi_resp_t   r;
        int          p0;
        p0 = pulse_cnt[1];
        do_write(32'h4, 32'hADAD_ABAB, 4'hF, r);
        do_write(32'h4, 32'h1122_3344, 4'b0101, r);
        do_read(32'h4, d, r);
        total++;
        if (d !== 32'hAD22_AB44 || r !== RESP_OKAY) begin
            bad++;
            $display("FAIL strobe_merge got %h/%b want ad22ab44/00", d, r);
        end
        total++;
        if (pulse_cnt[1] - p0 !== 2) begin
            bad++;
            $display("FAIL strobe_pulses got %0d want 2", pulse_cnt[1] - p0);
        end
    endtask

    task automatic test_w_before_aw;
        logic [31:0] d;
        axi_resp_t   r;
        int          p0;
        int          extra;
        p0 = pulse_cnt[2];
        w_send(32'h0000_00AA, 4'hF);
        repeat (3) @(negedge aclk);
        total++;
        if (bus.wready !== 1'b0 || bus.awready !== 1'b1 || bus.bvalid !== 1'b0) begin
            bad++;
            $display("FAIL w_held got wready=%b awready=%b bvalid=%b want 0/1/0",
                     bus.wready, bus.awready, bus.bvalid);
        end
        aw_send(32'h8);
        @(negedge aclk);
        total++;
        if (bus.bvalid !== 1'b0) begin
            bad++;
            $display("FAIL b_early got bvalid=%b want 0", bus.bvalid);
        end
        @(negedge aclk);
        total++;
        if (bus.bvalid !== 1'b1) begin
            bad++;
            $display("FAIL b_latency got bvalid=%b want 1", bus.bvalid);
        end
        b_wait(r);
        extra = 0;
        repeat (4) begin
            @(negedge aclk);
            if (bus.bvalid === 1'b1) extra++;
        end
        total++;
        if (r !== RESP_OKAY || extra !== 0) begin
            bad++;
            $display("FAIL b_single got resp=%b extra_bvalid=%0d want 00/0", r, extra);
        end
        do_read(32'h8, d, r);
        total++;
        if (d !== 32'h0000_00AA || pulse_cnt[2] - p0 !== 1) begin
            bad++;
            $display("FAIL w_first_read got %h pulses=%0d want 000000aa/1", d, pulse_cnt[2] - p0);
        end
    endtask

    task automatic test_errors;
        logic [31:0]  d;
        axi_resp_t    r;
        logic [255:0] snap;
        int           p0;
        snap = reg_out;
        p0 = 0;
        for (int i = 0; i < 8; i++) p0 += pulse_cnt[i];
        do_write(32'h20, 32'h1234_5678, 4'hF, r);
        total++;
        if (r !== RESP_SLVERR) begin
            bad++;
            $display("FAIL oor_write got %b want 10", r);
        end
        do_write(32'h1C, 32'h8765_4321, 4'hF, r);
        total++;
        if (r !== RESP_SLVERR) begin
            bad++;
            $display("FAIL ro_write got %b want 10", r);
        end
        do_read(32'h20, d, r);
        total++;
        if (d !== 32'h0 || r !== RESP_SLVERR) begin
            bad++;
            $display("FAIL oor_read got %h/%b want 00000000/10", d, r);
        end
        do_read(32'h1C, d, r);
        total++;
        if (d !== 32'hC0DE_0007 || r !== RESP_OKAY) begin
            bad++;
            $display("FAIL ro_read got %h/%b want c0de0007/00", d, r);
        end
        for (int i = 0; i < 8; i++) p0 -= pulse_cnt[i];
        total++;
        if (reg_out !== snap || p0 !== 0) begin
            bad++;
            $display("FAIL err_side_effect got reg_changed=%b pulses=%0d want 0/0",
                     reg_out !== snap, -p0);
        end
    endtask

    task automatic test_same_edge;
        logic [31:0] d;
        axi_resp_t   r;
        @(negedge aclk);
        bus.awaddr  = 32'h14;
        bus.awvalid = 1'b1;
        bus.wdata   = 32'h0BAD_F00D;
        bus.wstrb   = 4'hF;
        bus.wvalid  = 1'b1;
        total++;
        if (bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
            bad++;
            $display("FAIL same_aw_w_ready got %b%b want 11", bus.awready, bus.wready);
        end
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        @(negedge aclk);
        bus.araddr  = 32'h14;
        bus.arvalid = 1'b1;
        total++;
        if (bus.arready !== 1'b1) begin
            bad++;
            $display("FAIL same_ar_ready got %b want 1", bus.arready);
        end
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        r_recv(d, r);
        total++;
        if (d !== 32'h0000_5555 || r !== RESP_OKAY) begin
            bad++;
            $display("FAIL same_edge_old got %h/%b want 00005555/00", d, r);
        end
        b_wait(r);
        do_read(32'h14, d, r);
        total++;
        if (d !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL same_edge_new got %h want 0badf00d", d);
        end
    endtask

    task automatic test_b_stall;
        logic [31:0] d;
        axi_resp_t   r;
        int          n;
        int          errs;
        fork
            aw_send(32'h10);
            w_send(32'h0000_0C0C, 4'hF);
        join
        n = 0;
        while (bus.bvalid !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
        errs = 0;
        fork
            begin
                repeat (5) begin
                    @(negedge aclk);
                    if (bus.bvalid !== 1'b1 || bus.bresp !== RESP_OKAY ||
                        bus.awready !== 1'b0 || bus.wready !== 1'b0) errs++;
                end
            end
            do_read(32'h0, d, r);
        join
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL b_stall_hold got bad_cycles=%0d want 0", errs);
        end
        total++;
        if (d !== 32'hDEAD_BEEF || r !== RESP_OKAY) begin
            bad++;
            $display("FAIL stall_read got %h/%b want deadbeef/00", d, r);
        end
        b_wait(r);
        do_read(32'h10, d, r);
        total++;
        if (d !== 32'h0000_0C0C) begin
            bad++;
            $display("FAIL stall_write got %h want 00000c0c", d);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        axi_resp_t   r;
        int          stale;
        do_write(32'h0, 32'hBEBE_BABA, 4'hF, r);
        @(negedge aclk);
        bus.araddr  = 32'h0;
        bus.arvalid = 1'b1;
        #2;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        bus.arvalid = 1'b0;
        aresetn     = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge aclk);
            if (bus.rvalid !== 1'b0 || bus.bvalid !== 1'b0) stale++;
        end
        total++;
        if (stale !== 0) begin
            bad++;
            $display("FAIL mid_reset_stale got stale_cycles=%0d want 0", stale);
        end
        do_read(32'h0, d, r);
        total++;
        if (d !== 32'h0 || r !== RESP_OKAY || reg_out[31:0] !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset_value got %h/%b want 00000000/00", d, r);
        end
    endtask

    initial begin
        aresetn     = 1'b0;
        reg_in      = '0;
        reg_in[255:224] = 32'hC0DE_0007;
        bus.awaddr  = '0;
        bus.awprot  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arprot  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;

        test_reset();
        test_basic_write();
        test_strobes();
        test_w_before_aw();
        test_errors();
        test_same_edge();
        test_b_stall();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
